// File: rtl/oam_pkg.sv
// rtl/oam_pkg.sv - shared types and constants for the OAM responder
//
// Purpose: state encoding, word index type and sizing constants used by
// oam_ram and oam_bank.
// Ports: none (package).

package oam_pkg;

  // Byte address limit of the sprite attribute memory; each word holds two bytes.
  localparam logic [7:0] OAM_LIMIT = 8'hA0;
  localparam int         OAM_WORDS = int'(OAM_LIMIT) / 2;
  localparam logic [7:0] OAM_FILL  = 8'hFF;

  typedef logic [6:0] oam_word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } oam_state_t;

  function automatic logic oam_in_range(input oam_word_t word, input int words);
    return int'(word) < words;
  endfunction

endpackage

// File: rtl/oam_bank.sv
// rtl/oam_bank.sv - one 8-bit bank of the OAM word array
//
// Purpose: WORDS x 8 storage with a synchronous write port and a registered
// read port. Out-of-range reads return FILL; out-of-range writes are dropped.
// Ports:
//   clk, reset      system clock, synchronous active-high reset (read register only)
//   rd_en_i         load q_o from the array this cycle
//   rd_word_i       read word index
//   rd_data_o       unregistered read source (array or FILL)
//   q_o             registered read data
//   wr_en_i         write strobe
//   wr_word_i       write word index
//   wr_data_i       write data (true polarity)

module oam_bank
  import oam_pkg::*;
#(
  parameter int         WORDS = OAM_WORDS,
  parameter logic [7:0] FILL  = OAM_FILL
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rd_en_i,
  input  oam_word_t rd_word_i,
  output logic [7:0] rd_data_o,
  output logic [7:0] q_o,
  input  logic      wr_en_i,
  input  oam_word_t wr_word_i,
  input  logic [7:0] wr_data_i
);

  logic [7:0] mem_q [WORDS];
  logic [7:0] q_q, q_d;

  always_comb begin
    rd_data_o = FILL;
    if (oam_in_range(rd_word_i, WORDS)) begin
      rd_data_o = mem_q[rd_word_i];
    end
  end

  // The array has no reset: contents survive a reset of the responder.
  always_ff @(posedge clk) begin
    if (wr_en_i && oam_in_range(wr_word_i, WORDS)) begin
      mem_q[wr_word_i] <= wr_data_i;
    end
  end

  always_comb begin
    q_d = q_q;
    if (rd_en_i) begin
      q_d = rd_data_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= FILL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/oam_ram.sv
// rtl/oam_ram.sv - behavioural OAM responder (two 8-bit banks)
//
// Purpose: samples the active-low OAM access strobe, latches the address on
// its fall, serves word reads and CPU byte reads, and commits inverted write
// data on its rise.
// Ports:
//   clk, reset                    system clock, synchronous active-high reset
//   oam_a                         byte address ([7:1] word, [0] CPU bank select)
//   oam_a_nd, oam_b_nd            inverted write data for banks A/B
//   oam_clk                       access strobe, active low
//   oam_a_ncs, oam_b_ncs          per-bank write select, active low
//   oam_a_cpu_nrd, oam_b_cpu_nrd  per-bank CPU read enable, active low
//   oam_a_q, oam_b_q              word read data to the PPU latches
//   d_out, d_oe                   CPU read byte and its drive enable
//   busy                          access in progress

module oam_ram
  import oam_pkg::*;
#(
  parameter int         WORDS = OAM_WORDS,
  parameter logic [7:0] FILL  = OAM_FILL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] oam_a,
  input  logic [7:0] oam_a_nd,
  input  logic [7:0] oam_b_nd,
  input  logic       oam_clk,
  input  logic       oam_a_ncs,
  input  logic       oam_b_ncs,
  input  logic       oam_a_cpu_nrd,
  input  logic       oam_b_cpu_nrd,
  output logic [7:0] oam_a_q,
  output logic [7:0] oam_b_q,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       busy
);

  oam_state_t state_q, state_d;
  oam_word_t  word_q, word_d;
  logic       bsel_q, bsel_d;
  logic [7:0] d_out_q, d_out_d;
  logic       d_oe_q, d_oe_d;
  logic       oam_clk_q;
  logic       armed_q;

  logic       fall, rise;
  logic       a_we, b_we;
  logic [7:0] a_rd, b_rd;
  logic       nrd_at_fall, nrd_latched;

  // armed_q blocks a fall until the strobe has been seen high after reset,
  // so a strobe held low across reset release does not start an access.
  assign fall = armed_q & oam_clk_q & ~oam_clk & (state_q == IDLE);
  assign rise = ~oam_clk_q & oam_clk & (state_q == ACCESS);

  assign nrd_at_fall = oam_a[0] ? oam_b_cpu_nrd : oam_a_cpu_nrd;
  assign nrd_latched = bsel_q   ? oam_b_cpu_nrd : oam_a_cpu_nrd;

  // Writes use the word latched at the fall; reset wins over a coincident rise.
  assign a_we = rise & ~oam_a_ncs & ~reset;
  assign b_we = rise & ~oam_b_ncs & ~reset;

  oam_bank #(.WORDS(WORDS), .FILL(FILL)) u_bank_a (
    .clk       (clk),
    .reset     (reset),
    .rd_en_i   (fall),
    .rd_word_i (oam_a[7:1]),
    .rd_data_o (a_rd),
    .q_o       (oam_a_q),
    .wr_en_i   (a_we),
    .wr_word_i (word_q),
    .wr_data_i (~oam_a_nd)
  );

  oam_bank #(.WORDS(WORDS), .FILL(FILL)) u_bank_b (
    .clk       (clk),
    .reset     (reset),
    .rd_en_i   (fall),
    .rd_word_i (oam_a[7:1]),
    .rd_data_o (b_rd),
    .q_o       (oam_b_q),
    .wr_en_i   (b_we),
    .wr_word_i (word_q),
    .wr_data_i (~oam_b_nd)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bsel_d  = bsel_q;
    d_out_d = d_out_q;
    d_oe_d  = d_oe_q;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = ACCESS;
          word_d  = oam_a[7:1];
          bsel_d  = oam_a[0];
          d_oe_d  = ~nrd_at_fall;
          if (!nrd_at_fall) begin
            d_out_d = oam_a[0] ? b_rd : a_rd;
          end
        end
      end
      ACCESS: begin
        if (rise) begin
          state_d = IDLE;
          d_oe_d  = 1'b0;
        end else begin
          // d_out is held; only the drive enable follows the read strobe.
          d_oe_d = ~nrd_latched;
        end
      end
      default: begin
        state_d = IDLE;
        d_oe_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      bsel_q    <= 1'b0;
      d_out_q   <= FILL;
      d_oe_q    <= 1'b0;
      oam_clk_q <= 1'b1;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      bsel_q    <= bsel_d;
      d_out_q   <= d_out_d;
      d_oe_q    <= d_oe_d;
      oam_clk_q <= oam_clk;
      armed_q   <= armed_q | oam_clk;
    end
  end

  assign d_out = d_out_q;
  assign d_oe  = d_oe_q;
  assign busy  = (state_q == ACCESS);

endmodule

// File: tb/tb_oam_ram.sv
// tb/tb_oam_ram.sv - scoreboard testbench for oam_ram

module tb_oam_ram;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] oam_a, oam_a_nd, oam_b_nd;
  logic       oam_clk, oam_a_ncs, oam_b_ncs, oam_a_cpu_nrd, oam_b_cpu_nrd;
  logic [7:0] oam_a_q, oam_b_q, d_out;
  logic       d_oe, busy;

  always #5 clk = ~clk;

  oam_ram dut (
    .clk           (clk),
    .reset         (reset),
    .oam_a         (oam_a),
    .oam_a_nd      (oam_a_nd),
    .oam_b_nd      (oam_b_nd),
    .oam_clk       (oam_clk),
    .oam_a_ncs     (oam_a_ncs),
    .oam_b_ncs     (oam_b_ncs),
    .oam_a_cpu_nrd (oam_a_cpu_nrd),
    .oam_b_cpu_nrd (oam_b_cpu_nrd),
    .oam_a_q       (oam_a_q),
    .oam_b_q       (oam_b_q),
    .d_out         (d_out),
    .d_oe          (d_oe),
    .busy          (busy)
  );

  typedef struct {
    string      tag;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] dout;
    logic       doe;
    logic       busy;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_a [80];
  logic [7:0] mem_b [80];
  logic [7:0] dout_m = 8'hFF;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd_m(input logic bank, input logic [7:0] addr);
    logic [6:0] w;
    w = addr[7:1];
    if (w >= 7'd80) return 8'hFF;
    return bank ? mem_b[w] : mem_a[w];
  endfunction

  task automatic expect_out(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] dout, input logic doe, input logic bsy);
    exp_t e;
    e.tag = tag; e.a = a; e.b = b; e.dout = dout; e.doe = doe; e.busy = bsy;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, ".qa"},   {24'h0, oam_a_q}, {24'h0, e.a});
    check({e.tag, ".qb"},   {24'h0, oam_b_q}, {24'h0, e.b});
    check({e.tag, ".dout"}, {24'h0, d_out},   {24'h0, e.dout});
    check({e.tag, ".doe"},  {31'h0, d_oe},    {31'h0, e.doe});
    check({e.tag, ".busy"}, {31'h0, busy},    {31'h0, e.busy});
  endtask

  task automatic idle_inputs();
    oam_clk = 1'b1; oam_a_ncs = 1'b1; oam_b_ncs = 1'b1;
    oam_a_cpu_nrd = 1'b1; oam_b_cpu_nrd = 1'b1;
  endtask

  // One minimum-length access: one low sample, then high.
  task automatic do_access(input string tag, input logic [7:0] addr,
                           input logic [7:0] and_v, input logic [7:0] bnd_v,
                           input logic ancs, input logic bncs,
                           input logic anrd, input logic bnrd);
    logic [7:0] ea, eb;
    logic       snrd;
    @(posedge clk); #1;
    oam_a = addr; oam_a_nd = and_v; oam_b_nd = bnd_v;
    oam_a_ncs = ancs; oam_b_ncs = bncs;
    oam_a_cpu_nrd = anrd; oam_b_cpu_nrd = bnrd;
    oam_clk = 1'b0;
    ea = rd_m(1'b0, addr);
    eb = rd_m(1'b1, addr);
    snrd = addr[0] ? bnrd : anrd;
    if (!snrd) dout_m = addr[0] ? eb : ea;
    expect_out(tag, ea, eb, dout_m, !snrd, 1'b1);
    @(posedge clk); #1;
    compare_out();
    oam_clk = 1'b1;
    if (addr[7:1] < 7'd80) begin
      if (!ancs) mem_a[addr[7:1]] = ~and_v;
      if (!bncs) mem_b[addr[7:1]] = ~bnd_v;
    end
    expect_out({tag, ".end"}, ea, eb, dout_m, 1'b0, 1'b0);
    @(posedge clk); #1;
    compare_out();
    idle_inputs();
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] ea, eb;
    reset = 1'b1; oam_a = 8'h00; oam_a_nd = 8'hFF; oam_b_nd = 8'hFF;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    compare_out();
    reset = 1'b0;

    // Preload every word with a known pattern.
    for (int i = 0; i < 80; i++) begin
      do_access("fill", 8'(2 * i), ~8'(i * 3 + 1), ~(8'hC0 ^ 8'(i)), 1'b0, 1'b0, 1'b1, 1'b1);
    end

    // Write bank A only, then CPU read of bank A.
    do_access("wa", 8'h10, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    do_access("ra", 8'h10, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    check("ra.literal", {24'h0, oam_a_q}, 32'hA5);

    // Dual write to the last word, then a plain read.
    do_access("wlast", 8'h9E, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    do_access("rlast", 8'h9E, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);

    // Out of range: write dropped, reads give fill.
    do_access("woor", 8'hA0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    do_access("roor", 8'hA0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    do_access("rfe",  8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    do_access("rw0",  8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);

    // Address change mid-access: the fall address is used.
    @(posedge clk); #1;
    oam_a = 8'h20; oam_a_nd = 8'h33; oam_a_ncs = 1'b0; oam_b_ncs = 1'b1; oam_clk = 1'b0;
    ea = rd_m(1'b0, 8'h20); eb = rd_m(1'b1, 8'h20);
    expect_out("mid.fall", ea, eb, dout_m, 1'b0, 1'b1);
    @(posedge clk); #1;
    compare_out();
    oam_a = 8'h40;
    expect_out("mid.hold", ea, eb, dout_m, 1'b0, 1'b1);
    @(posedge clk); #1;
    compare_out();
    oam_clk = 1'b1;
    mem_a[8'h10] = 8'hCC;
    @(posedge clk); #1;
    idle_inputs();
    do_access("mid.r10", 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    do_access("mid.r20", 8'h40, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset mid-access: write lost, outputs to fill, low strobe not a fall.
    @(posedge clk); #1;
    oam_a = 8'h30; oam_a_nd = 8'h00; oam_b_nd = 8'h00;
    oam_a_ncs = 1'b0; oam_b_ncs = 1'b0; oam_a_cpu_nrd = 1'b0; oam_clk = 1'b0;
    ea = rd_m(1'b0, 8'h30); eb = rd_m(1'b1, 8'h30);
    dout_m = ea;
    expect_out("rst.fall", ea, eb, dout_m, 1'b1, 1'b1);
    @(posedge clk); #1;
    compare_out();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dout_m = 8'hFF;
    expect_out("rst.out", 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    compare_out();
    repeat (2) @(posedge clk);
    #1;
    expect_out("rst.lowhold", 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    compare_out();
    idle_inputs();
    @(posedge clk); #1;
    do_access("rst.read", 8'h30, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);

    // CPU byte select of bank B, read enable dropped mid-access.
    @(posedge clk); #1;
    oam_a = 8'h21; oam_b_cpu_nrd = 1'b0; oam_clk = 1'b0;
    ea = rd_m(1'b0, 8'h21); eb = rd_m(1'b1, 8'h21);
    dout_m = eb;
    expect_out("bsel.fall", ea, eb, dout_m, 1'b1, 1'b1);
    @(posedge clk); #1;
    compare_out();
    oam_b_cpu_nrd = 1'b1;
    expect_out("bsel.drop", ea, eb, dout_m, 1'b0, 1'b1);
    @(posedge clk); #1;
    compare_out();
    oam_clk = 1'b1;
    expect_out("bsel.end", ea, eb, dout_m, 1'b0, 1'b0);
    @(posedge clk); #1;
    compare_out();
    idle_inputs();

    // Random accesses against the model.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      do_access("rnd", ra, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
